// File: rtl/dpram_arb_if.sv
// Bus bundle between the dpram_arb block, its two requesters and one RAM port.
// The master side is the environment: both requesters plus the RAM read data.
interface dpram_arb_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          clrreq;
  logic          busy;
  logic          r0req;
  logic          r0we;
  logic [AW-1:0] r0a;
  logic [DW-1:0] r0d;
  logic          r0ack;
  logic [DW-1:0] r0q;
  logic          r1req;
  logic          r1we;
  logic [AW-1:0] r1a;
  logic [DW-1:0] r1d;
  logic          r1ack;
  logic [DW-1:0] r1q;
  logic [AW-1:0] ma;
  logic [DW-1:0] mi;
  logic [DW-1:0] mo;
  logic          mcs;
  logic          mwe;

  modport master (
    output clrreq, r0req, r0we, r0a, r0d, r1req, r1we, r1a, r1d, mo,
    input  busy, r0ack, r0q, r1ack, r1q, ma, mi, mcs, mwe
  );

  modport slave (
    input  clrreq, r0req, r0we, r0a, r0d, r1req, r1we, r1a, r1d, mo,
    output busy, r0ack, r0q, r1ack, r1q, ma, mi, mcs, mwe
  );
endinterface

// File: rtl/dpram_arb.sv
// Round-robin arbiter for two requesters sharing one port of a synchronous
// WRITE_FIRST block RAM, plus a sequencer that zero-fills the whole RAM after
// reset or on a clear request. Every bus output is registered.
module dpram_arb #(
  parameter int AW             = 10,
  parameter int DW             = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  dpram_arb_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_START,
    ST_CLR,
    ST_IDLE,
    ST_ACC,
    ST_CAP
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] ma_r, ma_n;
  logic [DW-1:0] mi_r, mi_n;
  logic          mcs_r, mcs_n;
  logic          mwe_r, mwe_n;
  logic          busy_r, busy_n;
  logic          r0ack_r, r0ack_n;
  logic          r1ack_r, r1ack_n;
  logic [DW-1:0] r0q_r, r0q_n;
  logic [DW-1:0] r1q_r, r1q_n;
  // Index of the most recently granted requester; the other one wins a tie.
  logic          last_r, last_n;
  // Requester that owns the access currently in flight.
  logic          gnt_r, gnt_n;
  logic          el0, el1, pick;

  assign bus.ma    = ma_r;
  assign bus.mi    = mi_r;
  assign bus.mcs   = mcs_r;
  assign bus.mwe   = mwe_r;
  assign bus.busy  = busy_r;
  assign bus.r0ack = r0ack_r;
  assign bus.r1ack = r1ack_r;
  assign bus.r0q   = r0q_r;
  assign bus.r1q   = r1q_r;

  // Next-state and next-output decode; RAM strobes and ACKs default low.
  always_comb begin
    state_n = state;
    ma_n    = ma_r;
    mi_n    = mi_r;
    mcs_n   = 1'b0;
    mwe_n   = 1'b0;
    busy_n  = busy_r;
    r0ack_n = 1'b0;
    r1ack_n = 1'b0;
    r0q_n   = r0q_r;
    r1q_n   = r1q_r;
    last_n  = last_r;
    gnt_n   = gnt_r;
    // A requester whose ACK is showing this cycle has not yet had a chance
    // to drop REQ, so it is masked to avoid a spurious repeat access.
    el0     = bus.r0req & ~r0ack_r;
    el1     = bus.r1req & ~r1ack_r;
    pick    = (el0 & el1) ? ~last_r : el1;

    case (state)
      ST_START: begin
        ma_n    = '0;
        mi_n    = '0;
        mcs_n   = 1'b1;
        mwe_n   = 1'b1;
        state_n = ST_CLR;
      end
      ST_CLR: begin
        if (&ma_r) begin
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end else begin
          ma_n  = ma_r + AW'(1);
          mcs_n = 1'b1;
          mwe_n = 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.clrreq) begin
          busy_n  = 1'b1;
          state_n = ST_START;
        end else if (el0 | el1) begin
          ma_n    = pick ? bus.r1a  : bus.r0a;
          mi_n    = pick ? bus.r1d  : bus.r0d;
          mwe_n   = pick ? bus.r1we : bus.r0we;
          mcs_n   = 1'b1;
          last_n  = pick;
          gnt_n   = pick;
          state_n = ST_ACC;
        end
      end
      ST_ACC: begin
        state_n = ST_CAP;
      end
      ST_CAP: begin
        // WRITE_FIRST RAM: on a write MO already carries the written data.
        if (gnt_r) begin
          r1q_n   = bus.mo;
          r1ack_n = 1'b1;
        end else begin
          r0q_n   = bus.mo;
          r0ack_n = 1'b1;
        end
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? ST_START : ST_IDLE;
      ma_r    <= '0;
      mi_r    <= '0;
      mcs_r   <= 1'b0;
      mwe_r   <= 1'b0;
      busy_r  <= CLEAR_ON_RESET;
      r0ack_r <= 1'b0;
      r1ack_r <= 1'b0;
      r0q_r   <= '0;
      r1q_r   <= '0;
      last_r  <= 1'b1;
      gnt_r   <= 1'b0;
    end else begin
      state   <= state_n;
      ma_r    <= ma_n;
      mi_r    <= mi_n;
      mcs_r   <= mcs_n;
      mwe_r   <= mwe_n;
      busy_r  <= busy_n;
      r0ack_r <= r0ack_n;
      r1ack_r <= r1ack_n;
      r0q_r   <= r0q_n;
      r1q_r   <= r1q_n;
      last_r  <= last_n;
      gnt_r   <= gnt_n;
    end
  end

endmodule

// File: tb/tb_dpram_arb.sv
// Bench for dpram_arb: owns a WRITE_FIRST RAM model on the shared port, drives
// both requesters and checks results against a word-array memory model and
// the round-robin grant rule.
module tb_dpram_arb;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpram_arb_if #(.AW(AW), .DW(DW)) bus ();

  dpram_arb #(.AW(AW), .DW(DW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] ram       [N];
  logic [DW-1:0] model_mem [N];
  int            model_last;
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            mon_bad = 0;
  bit            mcs_prev = 1'b0;
  logic [AW-1:0] wr_addr [$];

  bit            s_we [2][8];
  logic [AW-1:0] s_a  [2][8];
  logic [DW-1:0] s_d  [2][8];
  int            s_n  [2];
  int            ack_id  [$];
  int            ack_cyc [$];
  logic [DW-1:0] ack_q   [$];
  int            stream_to;

  // RAM port model: synchronous read, WRITE_FIRST.
  always @(posedge clk) begin
    if (bus.mcs === 1'b1) begin
      if (bus.mwe) begin
        ram[bus.ma] <= bus.mi;
        bus.mo      <= bus.mi;
      end else begin
        bus.mo <= ram[bus.ma];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol watch: never two ACKs at once, a granted access strobes MCS once.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.r0ack === 1'b1 && bus.r1ack === 1'b1) mon_bad++;
      if (bus.mcs === 1'b1 && bus.busy === 1'b0 && mcs_prev) mon_bad++;
    end
    mcs_prev = (bus.mcs === 1'b1);
  end

  task automatic idle_inputs();
    bus.clrreq = 1'b0;
    bus.r0req = 1'b0; bus.r0we = 1'b0; bus.r0a = '0; bus.r0d = '0;
    bus.r1req = 1'b0; bus.r1we = 1'b0; bus.r1a = '0; bus.r1d = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) model_mem[i] = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    model_last = 1;
  endtask

  // Follows a running clear until BUSY drops; edges counted from the call.
  task automatic wait_clear_done(output int edges, output int writes,
                                 output int seqerr, output int acks);
    edges = 0; writes = 0; seqerr = 0; acks = 0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #1;
      edges++;
      if (bus.r0ack || bus.r1ack) acks++;
      if (bus.mcs && bus.busy) begin
        if (!bus.mwe || bus.mi !== '0 || bus.ma !== AW'(writes)) seqerr++;
        writes++;
      end
      if (!bus.busy) break;
    end
  endtask

  task automatic access(input int r, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int budget,
                        output logic [DW-1:0] q, output int lat);
    int g;
    g = -1; lat = -1; q = 'x;
    if (r == 0) begin bus.r0we = we; bus.r0a = a; bus.r0d = d; bus.r0req = 1'b1; end
    else        begin bus.r1we = we; bus.r1a = a; bus.r1d = d; bus.r1req = 1'b1; end
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (g < 0 && bus.mcs && !bus.busy) g = i;
      if ((r == 0 && bus.r0ack) || (r == 1 && bus.r1ack)) begin
        q   = (r == 0) ? bus.r0q : bus.r1q;
        lat = (g < 0) ? -1 : i - g;
        break;
      end
    end
    if (r == 0) bus.r0req = 1'b0; else bus.r1req = 1'b0;
  endtask

  task automatic stream_req(input int r);
    bit found;
    for (int k = 0; k < s_n[r]; k++) begin
      if (r == 0) begin bus.r0we = s_we[0][k]; bus.r0a = s_a[0][k]; bus.r0d = s_d[0][k]; bus.r0req = 1'b1; end
      else        begin bus.r1we = s_we[1][k]; bus.r1a = s_a[1][k]; bus.r1d = s_d[1][k]; bus.r1req = 1'b1; end
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if ((r == 0) ? bus.r0ack : bus.r1ack) begin
          ack_id.push_back(r);
          ack_cyc.push_back(cyc);
          ack_q.push_back((r == 0) ? bus.r0q : bus.r1q);
          found = 1'b1;
          break;
        end
      end
      if (!found) begin stream_to++; break; end
    end
    if (r == 0) bus.r0req = 1'b0; else bus.r1req = 1'b0;
  endtask

  task automatic run_stream();
    ack_id.delete(); ack_cyc.delete(); ack_q.delete();
    stream_to = 0;
    fork
      stream_req(0);
      stream_req(1);
    join
  endtask

  task automatic test_reset();
    int edges, writes, seqerr, acks, nz;
    repeat (2) @(posedge clk); #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %0b want 1", bus.busy); end
    total++; if ({bus.mcs, bus.mwe, bus.r0ack, bus.r1ack} !== 4'b0) begin bad++; $display("FAIL rst_strobes: got %b want 0000", {bus.mcs, bus.mwe, bus.r0ack, bus.r1ack}); end
    total++; if ({bus.ma, bus.mi, bus.r0q, bus.r1q} !== '0) begin bad++; $display("FAIL rst_data: got ma=%0h mi=%0h q0=%0h q1=%0h want 0", bus.ma, bus.mi, bus.r0q, bus.r1q); end
    rst = 1'b0;
    model_clear();
    model_last = 1;
    wait_clear_done(edges, writes, seqerr, acks);
    total++; if (edges !== 1025) begin bad++; $display("FAIL clr_busy_edge: got %0d want 1025", edges); end
    total++; if (writes !== 1024 || seqerr !== 0) begin bad++; $display("FAIL clr_writes: got %0d (seqerr %0d) want 1024 (0)", writes, seqerr); end
    @(posedge clk); #1;
    nz = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== '0) nz++;
    total++; if (nz !== 0) begin bad++; $display("FAIL clr_ram_zero: got %0d nonzero words want 0", nz); end
    total++; if (ram[N-1] !== '0) begin bad++; $display("FAIL clr_last_word: got %0h want 0", ram[N-1]); end
  endtask

  task automatic test_single_rw();
    logic [DW-1:0] q, exp, d;
    logic [AW-1:0] a;
    int lat, r, latbad;
    bit we;
    access(0, 1'b1, AW'('h05A), 16'h1234, 20, q, lat);
    model_mem['h05A] = 16'h1234; model_last = 0; wr_addr.push_back(AW'('h05A));
    total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
    total++; if (q !== 16'h1234) begin bad++; $display("FAIL wr_q: got %0h want 1234", q); end
    access(0, 1'b0, AW'('h05A), 16'h0000, 20, q, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
    total++; if (q !== 16'h1234) begin bad++; $display("FAIL rd_q: got %0h want 1234", q); end
    latbad = 0;
    for (int i = 0; i < 14; i++) begin
      r  = $urandom_range(0, 1);
      we = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 'h2FF));
      d  = DW'($urandom);
      exp = we ? d : model_mem[a];
      access(r, we, a, d, 20, q, lat);
      if (lat != 2) latbad++;
      total++; if (q !== exp) begin bad++; $display("FAIL rand_q[%0d]: r=%0d we=%0b a=%0h got %0h want %0h", i, r, we, a, q, exp); end
      if (we) begin model_mem[a] = d; wr_addr.push_back(a); end
      model_last = r;
    end
    total++; if (latbad !== 0) begin bad++; $display("FAIL rand_latency: got %0d bad latencies want 0", latbad); end
  endtask

  task automatic test_back_to_back();
    int first, n0, n1, exp_id;
    logic [DW-1:0] exp;
    for (int k = 0; k < 4; k++) begin
      s_we[0][k] = 1'b1; s_a[0][k] = AW'('h300 + k); s_d[0][k] = DW'($urandom);
      s_we[1][k] = 1'b0; s_a[1][k] = wr_addr[k];      s_d[1][k] = DW'($urandom);
    end
    s_n[0] = 4; s_n[1] = 4;
    first = (model_last == 1) ? 0 : 1;
    run_stream();
    total++; if (ack_id.size() !== 8 || stream_to !== 0) begin bad++; $display("FAIL tie_count: got %0d acks (%0d timeouts) want 8", ack_id.size(), stream_to); end
    n0 = 0; n1 = 0;
    for (int k = 0; k < ack_id.size(); k++) begin
      exp_id = first ^ (k & 1);
      total++; if (ack_id[k] !== exp_id) begin bad++; $display("FAIL tie_order[%0d]: got %0d want %0d", k, ack_id[k], exp_id); end
      if (ack_id[k] == 0) begin exp = s_d[0][n0]; n0++; end
      else begin exp = model_mem[s_a[1][n1]]; n1++; end
      total++; if (ack_q[k] !== exp) begin bad++; $display("FAIL tie_q[%0d]: got %0h want %0h", k, ack_q[k], exp); end
      if (k > 0) begin
        total++; if (ack_cyc[k] - ack_cyc[k-1] !== 3) begin bad++; $display("FAIL tie_spacing[%0d]: got %0d want 3", k, ack_cyc[k] - ack_cyc[k-1]); end
      end
    end
    for (int k = 0; k < 4; k++) model_mem[s_a[0][k]] = s_d[0][k];
    model_last = first ^ 1;
  endtask

  task automatic test_same_requester();
    for (int k = 0; k < 3; k++) begin
      s_we[0][k] = 1'b0; s_a[0][k] = wr_addr[k + 1]; s_d[0][k] = DW'($urandom);
    end
    s_n[0] = 3; s_n[1] = 0;
    run_stream();
    total++; if (ack_id.size() !== 3 || stream_to !== 0) begin bad++; $display("FAIL hold_count: got %0d acks want 3", ack_id.size()); end
    for (int k = 0; k < ack_id.size(); k++) begin
      total++; if (ack_q[k] !== model_mem[s_a[0][k]]) begin bad++; $display("FAIL hold_q[%0d]: got %0h want %0h", k, ack_q[k], model_mem[s_a[0][k]]); end
      if (k > 0) begin
        total++; if (ack_cyc[k] - ack_cyc[k-1] !== 4) begin bad++; $display("FAIL hold_spacing[%0d]: got %0d want 4", k, ack_cyc[k] - ack_cyc[k-1]); end
      end
    end
    model_last = 0;
  endtask

  task automatic test_pending_clear();
    int e, fall, g, ack, early;
    logic [DW-1:0] q;
    ram['h010] = 16'hDEAD;
    apply_reset();
    repeat (4) @(posedge clk); #1;
    e = 4;
    bus.r1we = 1'b0; bus.r1a = AW'('h010); bus.r1d = 16'hFFFF; bus.r1req = 1'b1;
    fall = -1; g = -1; ack = -1; early = 0; q = 'x;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #1;
      e++;
      if (bus.busy && bus.mcs && (!bus.mwe || bus.mi !== '0)) early++;
      if (!bus.busy && fall < 0) fall = e;
      if (!bus.busy && bus.mcs && g < 0) g = e;
      if (bus.r1ack) begin ack = e; q = bus.r1q; break; end
    end
    bus.r1req = 1'b0;
    total++; if (early !== 0) begin bad++; $display("FAIL pend_no_grant: got %0d reads during clear want 0", early); end
    total++; if (fall !== 1025 || g !== 1026) begin bad++; $display("FAIL pend_grant_edge: got fall=%0d grant=%0d want 1025/1026", fall, g); end
    total++; if (ack !== 1028) begin bad++; $display("FAIL pend_ack_edge: got %0d want 1028", ack); end
    total++; if (q !== '0) begin bad++; $display("FAIL pend_q: got %0h want 0", q); end
    model_last = 1;
  endtask

  task automatic test_clrreq_collision();
    int e, writes, seqerr, fall, ack, lat;
    logic [DW-1:0] q;
    access(0, 1'b1, AW'('h3C3), 16'hBEEF, 20, q, lat);
    total++; if (q !== 16'hBEEF) begin bad++; $display("FAIL coll_prewrite: got %0h want beef", q); end
    @(posedge clk); #1;
    bus.clrreq = 1'b1;
    bus.r0we = 1'b0; bus.r0a = AW'('h3C3); bus.r0req = 1'b1;
    e = 0; writes = 0; seqerr = 0; fall = -1; ack = -1; q = 'x;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #1;
      e++;
      if (e == 1) begin
        bus.clrreq = 1'b0;
        total++; if (bus.busy !== 1'b1 || bus.mcs !== 1'b0) begin bad++; $display("FAIL coll_busy: got busy=%0b mcs=%0b want 1/0", bus.busy, bus.mcs); end
      end
      if (bus.busy && bus.mcs) begin
        if (!bus.mwe || bus.mi !== '0 || bus.ma !== AW'(writes)) seqerr++;
        writes++;
      end
      if (!bus.busy && fall < 0) fall = e;
      if (bus.r0ack) begin ack = e; q = bus.r0q; break; end
    end
    bus.r0req = 1'b0;
    total++; if (writes !== 1024 || seqerr !== 0) begin bad++; $display("FAIL coll_clear: got %0d writes (seqerr %0d) want 1024 (0)", writes, seqerr); end
    total++; if (fall !== 1026 || ack !== 1029) begin bad++; $display("FAIL coll_timing: got fall=%0d ack=%0d want 1026/1029", fall, ack); end
    total++; if (q !== '0) begin bad++; $display("FAIL coll_q: got %0h want 0", q); end
    model_clear();
    model_last = 0;
  endtask

  task automatic test_reset_mid();
    int edges, writes, seqerr, acks, lat, g;
    logic [DW-1:0] q;
    access(1, 1'b1, AW'('h111), 16'hA5A5, 20, q, lat);
    access(0, 1'b1, AW'('h222), 16'h5A5A, 20, q, lat);
    total++; if (bus.r0q !== 16'h5A5A || bus.r1q !== 16'hA5A5) begin bad++; $display("FAIL mid_pre_q: got %0h/%0h want 5a5a/a5a5", bus.r0q, bus.r1q); end
    bus.r0we = 1'b0; bus.r0a = AW'('h222); bus.r0req = 1'b1;
    g = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.mcs) begin g = 1; break; end
    end
    total++; if (g !== 1) begin bad++; $display("FAIL mid_grant: got %0d want 1", g); end
    rst = 1'b1;
    bus.r0req = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.r0ack !== 1'b0 || bus.r1ack !== 1'b0) begin bad++; $display("FAIL mid_no_ack: got %0b%0b want 00", bus.r0ack, bus.r1ack); end
    total++; if (bus.r0q !== '0 || bus.r1q !== '0) begin bad++; $display("FAIL mid_q_clear: got %0h/%0h want 0/0", bus.r0q, bus.r1q); end
    total++; if (bus.busy !== 1'b1 || bus.mcs !== 1'b0) begin bad++; $display("FAIL mid_rst_state: got busy=%0b mcs=%0b want 1/0", bus.busy, bus.mcs); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    model_last = 1;
    wait_clear_done(edges, writes, seqerr, acks);
    total++; if (edges !== 1025 || writes !== 1024 || seqerr !== 0) begin bad++; $display("FAIL mid_reclear: got edges=%0d writes=%0d seqerr=%0d want 1025/1024/0", edges, writes, seqerr); end
    total++; if (acks !== 0) begin bad++; $display("FAIL mid_late_ack: got %0d want 0", acks); end
  endtask

  task automatic test_protocol();
    total++; if (mon_bad !== 0) begin bad++; $display("FAIL protocol: got %0d violations want 0", mon_bad); end
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < N; i++) ram[i] = DW'($urandom) | 16'h0001;
    model_last = 1;
    test_reset();
    test_single_rw();
    test_back_to_back();
    test_same_requester();
    test_pending_clear();
    test_clrreq_collision();
    test_reset_mid();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
